// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry and display timing constants for the VGA path.
// Both the display read side and the pixel write side use these values.
package vga_pkg;

    localparam int FB_W      = 128;
    localparam int FB_H      = 128;
    localparam int FB_WORDS  = 2048;
    localparam int FB_ADDR_W = 11;

    localparam int H_SYNC = 128;
    localparam int H_BACK = 88;
    localparam int V_SYNC = 4;
    localparam int V_BACK = 23;

    localparam int WORD_W = 8;

    function automatic logic [WORD_W-1:0] fill_word(input logic v);
        return {WORD_W{v}};
    endfunction

endpackage

// File: rtl/fb_bit_merge.sv
// Replaces one bit of a frame-buffer word with a new pixel value.
// Purely combinational.
module fb_bit_merge (
    input  logic [7:0] word,
    input  logic [2:0] idx,
    input  logic       pix_bit,
    output logic [7:0] merged
);

    always_comb begin
        merged      = word;
        merged[idx] = pix_bit;
    end

endmodule

// File: rtl/vga_fb_writer.sv
// Write side of the 128x128 1-bpp frame buffer: per-pixel read-modify-write
// on 8-bit RAM words, plus a whole-frame clear/set fill.
module vga_fb_writer
    import vga_pkg::*;
#(
    parameter int X_W    = 7,
    parameter int Y_W    = 7,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int WORDS  = FB_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [X_W-1:0]    pix_x,
    input  logic [Y_W-1:0]    pix_y,
    input  logic              pix_bit,
    input  logic              fill_req,
    input  logic              fill_val,
    output logic              busy,
    output logic              pix_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_MOD,
        S_FILL
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t            state;
    state_t            next_state;
    logic              fill_pend;
    logic              fill_val_q;
    logic              fill_run;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] lat_addr;
    logic [2:0]        lat_idx;
    logic              lat_bit;
    logic [7:0]        rd_word;
    logic [7:0]        merged;
    logic              armed;

    fb_bit_merge u_merge (
        .word    (rd_word),
        .idx     (lat_idx),
        .pix_bit (lat_bit),
        .merged  (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (fill_req || fill_pend) begin
                    next_state = S_FILL;
                end else if (pix_valid && pix_ready) begin
                    next_state = S_RD;
                end
            end
            S_RD:   next_state = S_WAIT;
            S_WAIT: next_state = S_MOD;
            S_MOD:  next_state = S_IDLE;
            S_FILL: begin
                if (fill_run && (fill_addr == LAST_ADDR) && !fill_req) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The first FILL cycle is an entry cycle with no write; the sweep
    // then writes one word per clock, restarting at 0 on a new fill_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            fill_pend  <= 1'b0;
            fill_val_q <= 1'b0;
            fill_run   <= 1'b0;
            fill_addr  <= '0;
            lat_addr   <= '0;
            lat_idx    <= '0;
            lat_bit    <= 1'b0;
            rd_word    <= '0;
        end else begin
            armed <= 1'b1;

            if ((state == S_IDLE) && (next_state == S_RD)) begin
                lat_addr <= {pix_y, pix_x[X_W-1:3]};
                lat_idx  <= pix_x[2:0];
                lat_bit  <= pix_bit;
            end

            if (state == S_WAIT) begin
                rd_word <= ram_rdata;
            end

            if (fill_req) begin
                fill_val_q <= fill_val;
            end

            if ((state == S_IDLE) && (next_state == S_FILL)) begin
                fill_pend <= 1'b0;
            end else if (fill_req && ((state == S_RD) || (state == S_WAIT) || (state == S_MOD))) begin
                fill_pend <= 1'b1;
            end

            if (state != S_FILL) begin
                fill_run  <= 1'b0;
                fill_addr <= '0;
            end else begin
                fill_run <= 1'b1;
                if (fill_req || !fill_run) begin
                    fill_addr <= '0;
                end else begin
                    fill_addr <= fill_addr + 1'b1;
                end
            end
        end
    end

    // pix_ready also drops while fill_req is high so a same-cycle pixel
    // never sees a completed handshake that the fill then discards.
    always_comb begin
        pix_ready = 1'b0;
        pix_done  = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = lat_addr;
        ram_wdata = '0;
        busy      = (state != S_IDLE) || fill_pend;
        case (state)
            S_IDLE: begin
                pix_ready = armed && !fill_pend && !fill_req;
            end
            S_MOD: begin
                ram_we    = 1'b1;
                ram_wdata = merged;
                pix_done  = 1'b1;
            end
            S_FILL: begin
                ram_addr = fill_addr;
                ram_we   = fill_run;
                if (fill_run) begin
                    ram_wdata = fill_word(fill_val_q);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer with a behavioural 2048x8 sync RAM
// on the write port and a log of every RAM write.
module tb_vga_fb_writer;

    logic        clk;
    logic        rst_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [6:0]  pix_x;
    logic [6:0]  pix_y;
    logic        pix_bit;
    logic        fill_req;
    logic        fill_val;
    logic        busy;
    logic        pix_done;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:2047];
    int          wcount [0:2047];
    logic [10:0] wq_addr [$];
    logic [7:0]  wq_data [$];

    int checks = 0;
    int errors = 0;

    vga_fb_writer #(
        .X_W    (7),
        .Y_W    (7),
        .ADDR_W (11),
        .WORDS  (2048)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_bit   (pix_bit),
        .fill_req  (fill_req),
        .fill_val  (fill_val),
        .busy      (busy),
        .pix_done  (pix_done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]    <= ram_wdata;
            wcount[ram_addr] <= wcount[ram_addr] + 1;
            wq_addr.push_back(ram_addr);
            wq_data.push_back(ram_wdata);
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        pix_bit   = 1'b0;
        fill_req  = 1'b0;
        fill_val  = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        checks++; if (ram_addr !== 11'd0)  $display("FAIL reset_addr got %0d want 0", ram_addr);
        checks++; if (ram_we !== 1'b0)     $display("FAIL reset_we got %0b want 0", ram_we);
        checks++; if (ram_wdata !== 8'h00) $display("FAIL reset_wdata got %0h want 00", ram_wdata);
        checks++; if (pix_ready !== 1'b0)  $display("FAIL reset_ready got %0b want 0", pix_ready);
        checks++; if (pix_done !== 1'b0)   $display("FAIL reset_done got %0b want 0", pix_done);
        checks++; if (busy !== 1'b0)       $display("FAIL reset_busy got %0b want 0", busy);
        errors += (ram_addr !== 11'd0) + (ram_we !== 1'b0) + (ram_wdata !== 8'h00)
                + (pix_ready !== 1'b0) + (pix_done !== 1'b0) + (busy !== 1'b0);
        #2;
        rst_n = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_single_pixel;
        logic exp_we;
        logic exp_rdy;
        pix_x = 7'd9; pix_y = 7'd2; pix_bit = 1'b1; pix_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %0b want 1", pix_ready); end
        cyc();
        pix_valid = 1'b0; pix_x = 7'd0; pix_y = 7'd0; pix_bit = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp_we  = (c == 3);
            exp_rdy = (c == 4);
            checks++;
            if (ram_we !== exp_we) begin errors++; $display("FAIL single_we c=%0d got %0b want %0b", c, ram_we, exp_we); end
            checks++;
            if (pix_done !== exp_we) begin errors++; $display("FAIL single_done c=%0d got %0b want %0b", c, pix_done, exp_we); end
            checks++;
            if (pix_ready !== exp_rdy) begin errors++; $display("FAIL single_ready c=%0d got %0b want %0b", c, pix_ready, exp_rdy); end
            if (c <= 3) begin
                checks++;
                if (ram_addr !== 11'd33) begin errors++; $display("FAIL single_addr c=%0d got %0d want 33", c, ram_addr); end
            end
            if (c == 3) begin
                checks++;
                if (ram_wdata !== 8'h02) begin errors++; $display("FAIL single_wdata got %0h want 02", ram_wdata); end
            end
            cyc();
        end
        checks++;
        if (mem[33] !== 8'h02) begin errors++; $display("FAIL single_mem got %0h want 02", mem[33]); end
    endtask

    task automatic test_back_to_back;
        int last;
        int n;
        last = -1;
        n    = 0;
        pix_y = 7'd0; pix_x = 7'd0; pix_bit = 1'b1; pix_valid = 1'b1;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(negedge clk);
            if (pix_ready) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != 4) begin errors++; $display("FAIL b2b_gap got %0d want 4", c - last); end
                end
                last = c;
                n++;
                cyc();
                pix_x = 7'(n);
                if (n == 8) pix_valid = 1'b0;
            end else begin
                cyc();
            end
        end
        pix_valid = 1'b0;
        checks++;
        if (n != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", n); end
        repeat (5) cyc();
        checks++;
        if (mem[0] !== 8'hFF) begin errors++; $display("FAIL b2b_word0 got %0h want ff", mem[0]); end
        checks++;
        if (mem[1] !== 8'h00) begin errors++; $display("FAIL b2b_word1 got %0h want 00", mem[1]); end
    endtask

    task automatic test_fill(input logic v);
        int busy_n;
        int bad_data;
        int bad_cnt;
        bit done;
        logic [7:0] want;
        want = v ? 8'hFF : 8'h00;
        for (int i = 0; i < 2048; i++) wcount[i] = 0;
        fill_req = 1'b1; fill_val = v;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy_c0 got %0b want 0", busy); end
        cyc();
        fill_req = 1'b0; fill_val = ~v;
        busy_n = 0;
        done   = 1'b0;
        for (int c = 1; c < 2200 && !done; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            else done = 1'b1;
            cyc();
        end
        checks++;
        if (busy_n != 2049) begin errors++; $display("FAIL fill_busy_len v=%0b got %0d want 2049", v, busy_n); end
        bad_data = 0;
        bad_cnt  = 0;
        for (int i = 0; i < 2048; i++) begin
            if (mem[i] !== want) bad_data++;
            if (wcount[i] != 1) bad_cnt++;
        end
        checks++;
        if (bad_data != 0) begin errors++; $display("FAIL fill_data v=%0b got %0d bad words want 0", v, bad_data); end
        checks++;
        if (bad_cnt != 0) begin errors++; $display("FAIL fill_once v=%0b got %0d bad counts want 0", v, bad_cnt); end
    endtask

    task automatic test_fill_during_rmw;
        int busy_n;
        bit done;
        wq_addr.delete();
        wq_data.delete();
        pix_x = 7'd127; pix_y = 7'd127; pix_bit = 1'b1; pix_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL rmwfill_ready got %0b want 1", pix_ready); end
        cyc();
        pix_valid = 1'b0;
        cyc();
        fill_req = 1'b1; fill_val = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rmwfill_busy_wait got %0b want 1", busy); end
        cyc();
        fill_req = 1'b0; fill_val = 1'b0;
        busy_n = 0;
        done   = 1'b0;
        for (int c = 3; c < 2300 && !done; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            else done = 1'b1;
            cyc();
        end
        checks++;
        if (busy_n != 2051) begin errors++; $display("FAIL rmwfill_busy_len got %0d want 2051", busy_n); end
        checks++;
        if (wq_addr.size() != 2049) begin errors++; $display("FAIL rmwfill_nwrites got %0d want 2049", wq_addr.size()); end
        if (wq_addr.size() >= 2) begin
            checks++;
            if (wq_addr[0] !== 11'd2047 || wq_data[0] !== 8'h80) begin
                errors++; $display("FAIL rmwfill_first got %0d/%0h want 2047/80", wq_addr[0], wq_data[0]);
            end
            checks++;
            if (wq_addr[1] !== 11'd0 || wq_data[1] !== 8'hFF) begin
                errors++; $display("FAIL rmwfill_second got %0d/%0h want 0/ff", wq_addr[1], wq_data[1]);
            end
        end
    endtask

    task automatic test_fill_vs_pixel;
        int acc;
        wq_addr.delete();
        wq_data.delete();
        fill_req = 1'b1; fill_val = 1'b0;
        pix_valid = 1'b1; pix_x = 7'd3; pix_y = 7'd5; pix_bit = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got %0b want 0", pix_ready); end
        cyc();
        fill_req = 1'b0;
        acc = -1;
        for (int c = 1; c < 2200 && acc < 0; c++) begin
            @(negedge clk);
            if (pix_ready) acc = c;
            cyc();
        end
        pix_valid = 1'b0;
        checks++;
        if (acc != 2050) begin errors++; $display("FAIL prio_accept_cycle got %0d want 2050", acc); end
        repeat (4) cyc();
        checks++;
        if (wq_addr.size() != 2049) begin errors++; $display("FAIL prio_nwrites got %0d want 2049", wq_addr.size()); end
        if (wq_addr.size() >= 1) begin
            checks++;
            if (wq_addr[0] !== 11'd0 || wq_data[0] !== 8'h00) begin
                errors++; $display("FAIL prio_first got %0d/%0h want 0/00", wq_addr[0], wq_data[0]);
            end
        end
        checks++;
        if (mem[80] !== 8'h08) begin errors++; $display("FAIL prio_mem got %0h want 08", mem[80]); end
    endtask

    task automatic test_reset_mid_fill;
        bit found;
        bit seen;
        fill_req = 1'b1; fill_val = 1'b1;
        cyc();
        fill_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 700 && !found; c++) begin
            @(negedge clk);
            if (ram_we && ram_addr == 11'd500) found = 1'b1;
            else cyc();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_fill_reach500 got 0 want 1"); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (ram_addr !== 11'd0)  begin errors++; $display("FAIL rst_async_addr got %0d want 0", ram_addr); end
        checks++; if (ram_we !== 1'b0)     begin errors++; $display("FAIL rst_async_we got %0b want 0", ram_we); end
        checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL rst_async_wdata got %0h want 00", ram_wdata); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_async_busy got %0b want 0", busy); end
        checks++; if (pix_ready !== 1'b0)  begin errors++; $display("FAIL rst_async_ready got %0b want 0", pix_ready); end
        checks++; if (pix_done !== 1'b0)   begin errors++; $display("FAIL rst_async_done got %0b want 0", pix_done); end
        repeat (2) cyc();
        checks++; if (mem[499] !== 8'hFF)  begin errors++; $display("FAIL rst_mem499 got %0h want ff", mem[499]); end
        checks++; if (mem[500] !== 8'h00)  begin errors++; $display("FAIL rst_mem500 got %0h want 00", mem[500]); end
        checks++; if (mem[1000] !== 8'h00) begin errors++; $display("FAIL rst_mem1000 got %0h want 00", mem[1000]); end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) cyc();
        pix_x = 7'd9; pix_y = 7'd2; pix_bit = 1'b0; pix_valid = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (pix_ready) found = 1'b1;
            cyc();
        end
        pix_valid = 1'b0;
        checks++;
        if (!found) begin errors++; $display("FAIL post_rst_accept got 0 want 1"); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (pix_done) begin
                seen = 1'b1;
                checks++;
                if (ram_addr !== 11'd33 || ram_wdata !== 8'hFD) begin
                    errors++; $display("FAIL post_rst_write got %0d/%0h want 33/fd", ram_addr, ram_wdata);
                end
            end
            cyc();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL post_rst_done got 0 want 1"); end
        checks++;
        if (mem[33] !== 8'hFD) begin errors++; $display("FAIL post_rst_mem got %0h want fd", mem[33]); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]    = 8'h00;
            wcount[i] = 0;
        end
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_fill(1'b1);
        test_fill(1'b0);
        test_fill_during_rmw();
        test_fill(1'b0);
        test_fill_vs_pixel();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
